// File: rtl/atomrvcore_wb_arbiter_pkg.sv
// Shared types and default sizes for the writeback arbiter slice of the core.
package atomrvcore_wb_arbiter_pkg;

    localparam int unsigned DATAWIDTH        = 32;
    localparam int unsigned REG_ADRESS_WIDTH = 5;
    localparam int unsigned REGISTERS        = 2 ** REG_ADRESS_WIDTH;
    localparam int unsigned NREQ             = 3;

    // Writeback requester slots, in arbitration index order.
    typedef enum logic [1:0] {
        REQ_ALU   = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_UPPER = 2'd2
    } req_idx_e;

endpackage

// File: rtl/atomrvcore_wb_arbiter_rr.sv
// Round-robin grant logic: owns the search pointer and issues a one-hot grant.
module atomrvcore_wb_arbiter_rr
    import atomrvcore_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = atomrvcore_wb_arbiter_pkg::NREQ
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] valid_i,
    output logic [NREQ-1:0] grant_o
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] gnt_idx;
    logic            gnt_any;

    // Search upward from ptr_q (wrapping at NREQ); the first valid requester wins.
    always_comb begin
        int unsigned idx;
        grant_o = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (!rst_i) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                idx = 32'(ptr_q) + i;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!gnt_any && valid_i[idx[PtrW-1:0]]) begin
                    gnt_any                  = 1'b1;
                    gnt_idx                  = idx[PtrW-1:0];
                    grant_o[idx[PtrW-1:0]]   = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the granted requester; holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/atomrvcore_wb_arbiter.sv
// Writeback arbiter: picks one requester per cycle, registers its write for the
// register file, and tracks destination registers with writes still pending.
module atomrvcore_wb_arbiter #(
    parameter int unsigned DATAWIDTH        = atomrvcore_wb_arbiter_pkg::DATAWIDTH,
    parameter int unsigned REG_ADRESS_WIDTH = atomrvcore_wb_arbiter_pkg::REG_ADRESS_WIDTH,
    parameter int unsigned NREQ             = atomrvcore_wb_arbiter_pkg::NREQ
) (
    input  logic                                  clk_i,
    input  logic                                  regrst_i,
    input  logic [NREQ-1:0]                       req_valid_i,
    input  logic [NREQ-1:0][REG_ADRESS_WIDTH-1:0] req_rd_i,
    input  logic [NREQ-1:0][DATAWIDTH-1:0]        req_data_i,
    output logic [NREQ-1:0]                       req_ready_o,
    output logic [REG_ADRESS_WIDTH-1:0]           RD_o,
    output logic [DATAWIDTH-1:0]                  WR_o,
    output logic                                  RWR_EN_o,
    input  logic                                  issue_en_i,
    input  logic [REG_ADRESS_WIDTH-1:0]           issue_rd_i,
    input  logic [REG_ADRESS_WIDTH-1:0]           RS1_i,
    input  logic [REG_ADRESS_WIDTH-1:0]           RS2_i,
    output logic                                  rs1_busy_o,
    output logic                                  rs2_busy_o
);

    import atomrvcore_wb_arbiter_pkg::*;

    localparam int unsigned Regs = 2 ** REG_ADRESS_WIDTH;

    logic [NREQ-1:0]             grant;
    logic                        accept;
    logic [REG_ADRESS_WIDTH-1:0] sel_rd;
    logic [DATAWIDTH-1:0]        sel_data;

    logic [REG_ADRESS_WIDTH-1:0] rd_q;
    logic [DATAWIDTH-1:0]        wr_q;
    logic                        wen_q;
    logic [Regs-1:0]             busy_q, busy_d;

    atomrvcore_wb_arbiter_rr #(
        .NREQ (NREQ)
    ) u_rr (
        .clk_i   (clk_i),
        .rst_i   (regrst_i),
        .valid_i (req_valid_i),
        .grant_o (grant)
    );

    assign req_ready_o = grant;
    assign accept      = |grant;

    // Grant is one-hot, so an OR across the granted lanes selects the winner.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd | req_rd_i[i];
                sel_data = sel_data | req_data_i[i];
            end
        end
    end

    // Write port register: one-cycle latency; x0 writes are accepted but dropped.
    always_ff @(posedge clk_i) begin
        if (regrst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            wen_q <= 1'b0;
        end else if (accept && (sel_rd != '0)) begin
            rd_q  <= sel_rd;
            wr_q  <= sel_data;
            wen_q <= 1'b1;
        end else begin
            wen_q <= 1'b0;
        end
    end

    // Reset masks the write port immediately so a write registered just before
    // reset never reaches the register file.
    always_comb begin
        RWR_EN_o = wen_q & ~regrst_i;
        RD_o     = regrst_i ? '0 : rd_q;
        WR_o     = regrst_i ? '0 : wr_q;
    end

    // Pending-write scoreboard: clear on retire, then set on issue so a newer
    // producer of the same register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (RWR_EN_o) begin
            busy_d[RD_o] = 1'b0;
        end
        if (issue_en_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (regrst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Source lookups read the registered scoreboard only; no bypass of the
    // write currently on the port.
    always_comb begin
        rs1_busy_o = busy_q[RS1_i] & ~regrst_i;
        rs2_busy_o = busy_q[RS2_i] & ~regrst_i;
    end

endmodule

// File: doc/atomrvcore_wb_arbiter.md
ATOMRVCORE_WB_ARBITER -- requirements
Module: atomRVCORE_wb_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32, register data width.
REQ-002 Parameter REG_ADRESS_WIDTH, default 5, register index width.
REQ-003 Parameter NREQ, default 3, number of writeback requesters (0=ALU, 1=load, 2=JAL/JALR/LUI/AUIPC).
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 regrst_i  input  1  reset, synchronous, active-high.
REQ-006 req_valid_i  input  NREQ  per-requester writeback request.
REQ-007 req_rd_i  input  NREQ x REG_ADRESS_WIDTH  per-requester destination register.
REQ-008 req_data_i  input  NREQ x DATAWIDTH  per-requester writeback data.
REQ-009 req_ready_o  output  NREQ  one-hot grant; request accepted on a cycle where valid and ready are both high.
REQ-010 RD_o  output  REG_ADRESS_WIDTH  register-file write address.
REQ-011 WR_o  output  DATAWIDTH  register-file write data.
REQ-012 RWR_EN_o  output  1  register-file write enable.
REQ-013 issue_en_i / issue_rd_i  input  1 / REG_ADRESS_WIDTH  instruction issued that will later write issue_rd_i.
REQ-014 RS1_i / RS2_i  input  REG_ADRESS_WIDTH each  source registers to check.
REQ-015 rs1_busy_o / rs2_busy_o  output  1 each  source has a pending write.

Function
REQ-016 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, ascends modulo NREQ; first requester with valid high is granted.
REQ-017 req_ready_o SHALL be combinational from req_valid_i and rr_ptr; at most one bit high; all zero when no valid.
REQ-018 On a grant to index g, rr_ptr SHALL become (g+1) mod NREQ next cycle; with no grant rr_ptr SHALL hold.
REQ-019 A requester SHALL hold valid, rd and data stable until accepted; the arbiter SHALL NOT drop a granted request.
REQ-020 Accepted rd/data SHALL be registered: RD_o/WR_o update and RWR_EN_o is high exactly one cycle after acceptance, for one cycle (latency 1, throughput 1 write/cycle).
REQ-021 Accepted request with rd=0 SHALL drive RWR_EN_o low that cycle (x0 write dropped) and SHALL NOT touch the scoreboard.
REQ-022 Scoreboard busy[REGISTERS-1:0]: issue_en_i with issue_rd_i!=0 SETS busy[issue_rd_i] next cycle.
REQ-023 A cycle with RWR_EN_o high SHALL clear busy[RD_o] next cycle.
REQ-024 Simultaneous set and clear of the same register: set SHALL win (newer producer pending).
REQ-025 busy[0] SHALL be constant 0.
REQ-026 rsN_busy_o SHALL be combinational busy[RSN_i]; no bypass of an in-flight RWR_EN_o.
REQ-027 Starvation bound: a continuously valid requester SHALL be granted within NREQ cycles.

Reset
REQ-028 While regrst_i is high: req_ready_o=0, RWR_EN_o=0, RD_o=0, WR_o=0, busy all 0, rr_ptr=0; inputs ignored.
REQ-029 Reset asserted with a write registered SHALL cancel it (RWR_EN_o low the following cycle).
REQ-030 First grant after reset release SHALL use rr_ptr=0.

Structure
REQ-031 Shared package atomRVCORE_pkg SHALL hold DATAWIDTH, REG_ADRESS_WIDTH, REGISTERS, NREQ and requester-index enum (REQ_ALU, REQ_LOAD, REQ_UPPER).
REQ-032 Round-robin grant/pointer logic SHALL be sub-module atomRVCORE_rr_arbiter (inputs valid, outputs one-hot grant, owns rr_ptr).
REQ-033 Outputs RD_o/WR_o/RWR_EN_o SHALL connect directly to the register file write port, replacing its internal source select.

Verification
REQ-034 After reset, valid=3'b111, rd={5,6,7}, data={A,B,C} held -> grants ALU, load, upper in cycles 1,2,3; RWR_EN_o high cycles 2-4 with (5,A),(6,B),(7,C).
REQ-035 Only load valid, rd=0, data=0xDEADBEEF -> ready[1] high one cycle, RWR_EN_o stays 0, busy unchanged.
REQ-036 issue rd=9 cycle 0; load writes rd=9 accepted cycle 3 -> rs1_busy_o (RS1_i=9) high cycles 1-4, low cycle 5.
REQ-037 issue rd=12 on same cycle RWR_EN_o writes rd=12 -> busy[12] remains 1.
REQ-038 ALU held valid continuously, load valid from cycle 2 -> load granted by cycle 3; no requester waits more than 3 cycles.
REQ-039 regrst_i pulsed one cycle right after acceptance of rd=4 -> RWR_EN_o never high for it; busy all 0; next grant starts at ALU.
